// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/fetch_unit.sv
// nRisc instruction-fetch stage: PC, req/ack fetch from instruction memory, instruction register.
// Optional macro FETCH_TIMEOUT_EN aborts a fetch after TIMEOUT unacknowledged cycles and flags erro.
module fetch_unit #(
    parameter int                 ADDR_W    = 8,
    parameter int                 INSTR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 8'b00001000,
    parameter int                 TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               escritaPC,
    input  logic               pula,
    input  logic [ADDR_W-1:0]  alvo,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instru,
    output logic               instru_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               erro
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_EXEC  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instru_q, instru_d;
    logic               valid_q, valid_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             erro_q, erro_d;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        instru_d = instru_q;
        valid_d  = valid_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d    = tmo_q;
        erro_d   = erro_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (req_q && imem.imem_ack) begin
                    instru_d = imem.imem_data;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = S_EXEC;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
`ifdef FETCH_TIMEOUT_EN
                // Give up on a silent memory: hand the core a NOP so it keeps running.
                else if (req_q && tmo_q == TMO_LAST) begin
                    instru_d = NOP_INSTR;
                    valid_d  = 1'b1;
                    erro_d   = 1'b1;
                    req_d    = 1'b0;
                    state_d  = S_EXEC;
                    tmo_d    = '0;
                end
`endif
                else begin
                    req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    if (req_q) tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            S_EXEC: begin
`ifdef FETCH_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (escritaPC) begin
                    pc_d     = pula ? alvo : pc_q + 1'b1;
                    instru_d = NOP_INSTR;
                    valid_d  = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            instru_q <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            instru_q <= instru_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            erro_q <= erro_d;
        end
    end

    assign erro = erro_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign erro = 1'b0;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instru         = instru_q;
    assign instru_valid   = valid_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: memory responder, PC reference model and output monitor.
module tb_fetch_unit;
    localparam logic [7:0] NOP = 8'h08;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       escritaPC = 1'b0;
    logic       pula = 1'b0;
    logic [7:0] alvo = 8'h00;
    logic [7:0] instru;
    logic       instru_valid;
    logic [7:0] pc;
    logic       erro;

    fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) imem_bus ();

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .escritaPC    (escritaPC),
        .pula         (pula),
        .alvo         (alvo),
        .imem         (imem_bus),
        .instru       (instru),
        .instru_valid (instru_valid),
        .pc           (pc),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_pc = 8'h00;
    logic       exp_erro = 1'b0;
    logic [7:0] exp_addr_q[$];
    logic [8:0] exp_instr_q[$];   // {erro expected after this load, instruction}
    int         next_delay = 0;
    int         next_data = -1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after a chosen delay and records what it returned.
    bit         busy = 1'b0;
    int         cnt = 0;
    int         dly = 0;
    logic [7:0] addr0 = 8'h00;
    logic [7:0] rdata;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                imem_bus.imem_ack = 1'b0;
                busy = 1'b0;
                cnt = 0;
            end else if (imem_bus.imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    dly = next_delay;
                    addr0 = imem_bus.imem_addr;
                    if (exp_addr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL req_addr: got request at %h expected none", imem_bus.imem_addr);
                    end else begin
                        check8("req_addr", imem_bus.imem_addr, exp_addr_q.pop_front());
                    end
                end else begin
                    check8("addr_stable", imem_bus.imem_addr, addr0);
                end
                if (cnt == dly) begin
                    rdata = (next_data < 0) ? 8'($urandom) : 8'(next_data);
                    imem_bus.imem_ack = 1'b1;
                    imem_bus.imem_data = rdata;
                    exp_instr_q.push_back({1'b0, rdata});
                end else begin
                    imem_bus.imem_ack = 1'b0;
                    imem_bus.imem_data = 8'($urandom);
                    cnt++;
                end
            end else begin
                // Spurious acks with no request outstanding must be ignored.
                busy = 1'b0;
                imem_bus.imem_ack = 1'($urandom);
                imem_bus.imem_data = 8'($urandom);
            end
        end
    end

    // Monitor: pc, erro and instruction register against the reference model.
    logic       prev_v = 1'b0;
    logic [7:0] held = 8'h00;
    logic [8:0] e;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_v = 1'b0;
            end else begin
                check8("pc", pc, exp_pc);
                if (instru_valid && !prev_v) begin
                    if (exp_instr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL instr_load: got %h expected no load", instru);
                    end else begin
                        e = exp_instr_q.pop_front();
                        exp_erro = exp_erro | e[8];
                        check8("instr_load", instru, e[7:0]);
                    end
                    held = instru;
                end else if (instru_valid) begin
                    check8("instr_hold", instru, held);
                end else begin
                    check8("instr_nop", instru, NOP);
                end
                check1("erro", erro, exp_erro);
                prev_v = instru_valid;
            end
        end
    end

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instru_valid && n < 60);
        if (!instru_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: got instru_valid=0 expected 1 within 60 cycles");
        end
    endtask

    // One executed instruction: idle in EXEC, then pulse escritaPC (optionally held into FETCH).
    task automatic exec_step(input bit pl, input logic [7:0] tg, input int d, input int dat, input int hold);
        wait_valid();
        repeat ($urandom_range(0, 2)) begin
            pula = 1'($urandom);
            alvo = 8'($urandom);
            @(negedge clk);
        end
        next_delay = d;
        next_data = dat;
        pula = pl;
        alvo = tg;
        escritaPC = 1'b1;
        @(posedge clk); #1;
        exp_pc = pl ? tg : exp_pc + 8'd1;
        exp_addr_q.push_back(exp_pc);
        check8("pc_update", pc, exp_pc);
        check1("req_low", imem_bus.imem_req, 1'b0);
        check1("valid_clr", instru_valid, 1'b0);
        check8("instr_clr", instru, NOP);
        if (hold == 0) escritaPC = 1'b0;
        pula = 1'($urandom);
        alvo = 8'($urandom);
        @(posedge clk); #1;
        check1("req_rise", imem_bus.imem_req, 1'b1);
        check8("fetch_addr", imem_bus.imem_addr, exp_pc);
        if (hold > 1) begin
            repeat (hold - 1) begin
                pula = 1'($urandom);
                alvo = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        escritaPC = 1'b0;
        pula = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish by 400000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_data = 8'h00;
        #1 reset = 1'b0;
        #1;
        check8("rst_pc", pc, 8'h00);
        check1("rst_req", imem_bus.imem_req, 1'b0);
        check8("rst_instr", instru, NOP);
        check1("rst_valid", instru_valid, 1'b0);
        check1("rst_erro", erro, 1'b0);

        next_delay = 0;
        next_data = 8'h00;
        exp_addr_q.push_back(8'h00);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check1("first_req", imem_bus.imem_req, 1'b1);
        check8("first_addr", imem_bus.imem_addr, 8'h00);
        @(posedge clk); #1;
        check1("first_valid", instru_valid, 1'b1);
        check8("first_instr", instru, 8'h00);
        check1("first_req_drop", imem_bus.imem_req, 1'b0);

        repeat (3) exec_step(1'b0, 8'h00, 1, -1, 0);   // pc 1,2,3
        exec_step(1'b0, 8'h00, 0, -1, 0);              // 3 -> 4
        exec_step(1'b0, 8'h00, 0, -1, 0);              // 4 -> 5
        exec_step(1'b1, 8'h20, 2, -1, 1);              // jump to 0x20
        exec_step(1'b1, 8'hFF, 0, -1, 0);
        exec_step(1'b0, 8'h00, 1, -1, 0);              // 0xFF wraps to 0x00
        exec_step(1'b0, 8'h00, 3, 8'h05, 3);           // late ack, escritaPC held during wait
        wait_valid();
        check8("late_data", instru, 8'h05);

        repeat (150) begin
            d = $urandom_range(0, 4);
            exec_step(1'($urandom), 8'($urandom), d, -1, $urandom_range(0, d + 1));
        end

`ifdef FETCH_TIMEOUT_EN
        wait_valid();
        exp_instr_q.push_back({1'b1, NOP});
        exec_step(1'b0, 8'h00, 1000, -1, 0);
        wait_valid();
        check1("tmo_erro", erro, 1'b1);
        check8("tmo_instr", instru, NOP);
`endif

        // Asynchronous reset while a request is outstanding.
        exec_step(1'b0, 8'h00, 6, -1, 0);
        #2 reset = 1'b0;
        exp_pc = 8'h00;
        exp_erro = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        #1;
        check1("async_req", imem_bus.imem_req, 1'b0);
        check8("async_pc", pc, 8'h00);
        check1("async_valid", instru_valid, 1'b0);
        check8("async_instr", instru, NOP);
        check1("async_erro", erro, 1'b0);

        next_delay = 1;
        next_data = -1;
        exp_addr_q.push_back(8'h00);
        @(posedge clk); #1 reset = 1'b1;
        exec_step(1'b1, 8'h42, 2, -1, 1);
        wait_valid();
        @(negedge clk);
        total++;
        if (exp_instr_q.size() != 0 || exp_addr_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_instr_q.size(), exp_addr_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the nRisc core, directly upstream of the control unit.
- Holds the PC, requests instructions from instruction memory over a req/ack handshake, and latches each into an instruction register driving `instru`.
- Advances the PC (sequential or jump) only when the control unit pulses `escritaPC`.
- During a fetch, `instru` holds NOP (8'b00001000, all control lines low), so the control unit never decodes stale data.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 8, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 8'b00001000, value driven on `instru` while no valid instruction is held.
- TIMEOUT, 15, cycles to wait for `imem_ack` before aborting (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- escritaPC  in  1  PC write enable from control unit; sampled only in EXEC.
- pula  in  1  jump taken; qualifies `escritaPC`.
- alvo  in  ADDR_W  jump target address.
- imem_req  out  1  instruction-memory request; registered.
- imem_addr  out  ADDR_W  request address; equals `pc`.
- imem_ack  in  1  memory handshake; `imem_data` is valid in the same cycle.
- imem_data  in  INSTR_W  instruction returned by memory.
- instru  out  INSTR_W  instruction register, feeds control unit.
- instru_valid  out  1  `instru` holds a fetched instruction.
- pc  out  ADDR_W  current program counter.
- erro  out  1  sticky fetch-timeout flag (0 unless FETCH_TIMEOUT_EN).

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, instru=NOP_INSTR, instru_valid=0, erro=0, timeout counter=0.
- FSM has two states, FETCH and EXEC.
- FETCH:
  - imem_req=1 from the first clock edge after reset deassertion, or the edge after entry.
  - imem_addr=pc; instru=NOP_INSTR; instru_valid=0.
  - On a cycle with imem_req=1 and imem_ack=1: instru<=imem_data, instru_valid<=1, imem_req<=0, state<=EXEC.
  - Minimum latency from req rising to instru_valid is 1 cycle (ack in the same cycle as req).
- EXEC:
  - instru stays stable, imem_req=0, pc unchanged until escritaPC=1.
  - On escritaPC=1: pc<=(pula ? alvo : pc+1), instru<=NOP_INSTR, instru_valid<=0, state<=FETCH.
  - imem_req re-asserts on the next edge.
- Ignored inputs:
  - escritaPC and pula in FETCH.
  - pula without escritaPC.
  - imem_ack while imem_req=0.
- pc+1 wraps modulo 2^ADDR_W (8'hFF -> 8'h00); alvo is taken verbatim.
- escritaPC held high across several cycles: only the cycle in EXEC takes effect; the following FETCH cycles ignore it.
- Reset during an outstanding request drops imem_req immediately (asynchronously); any late ack after release is ignored until the new request.
- imem_addr must remain stable while imem_req=1.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs while FETCH has imem_req=1 without ack.
  - If TIMEOUT cycles elapse, load instru=NOP_INSTR, set instru_valid=1 and erro=1 (sticky until reset), and go to EXEC so the core does not hang.
  - The counter clears on ack or on leaving FETCH.
- Undefined: no counter; FETCH waits indefinitely; erro tied 0.

Test Plan:
- Reset release, memory acks same cycle with data 8'h00 -> imem_req=1, imem_addr=0 on first edge; next edge instru=8'h00, instru_valid=1, imem_req=0.
- EXEC, pc=3, pulse escritaPC with pula=0 -> pc=4, instru=8'h08, instru_valid=0; imem_req=1 with imem_addr=4 the following cycle.
- EXEC, pc=5, escritaPC=1, pula=1, alvo=8'h20 -> pc=8'h20, fetch issued at 8'h20.
- pc=8'hFF, escritaPC=1, pula=0 -> pc=8'h00.
- Memory acks 3 cycles late with 8'h05; escritaPC pulses during wait -> instru stays 8'h08 and pc unchanged until ack; then instru=8'h05.
- reset=0 mid-fetch -> imem_req=0 and pc=RESET_PC immediately, without a clock edge.
- With FETCH_TIMEOUT_EN, no ack for 15 cycles -> erro=1, instru_valid=1, instru=8'h08.
